// File: rtl/imem_prog_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them
// through the instruction memory external port, then releases the CPU.
module imem_prog_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int          MAX_WORDS = 128,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic [31:0]      wdata_ext,
  output logic             cpu_enable,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  localparam int                 IDX_W   = $clog2(MAX_WORDS + 1);
  localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0]   CNT_SAT = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       byte_idx;
  logic [IDX_W-1:0] word_idx;
  logic [23:0]      shadow;
  logic             last_q;
  logic             accept;
  logic [63:0]      wr_addr;

  assign accept  = s_valid && s_ready;
  // Address wraps naturally in 64-bit arithmetic.
  assign wr_addr = BASE_ADDR + (64'(word_idx) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= '0;
      word_idx   <= '0;
      shadow     <= '0;
      last_q     <= 1'b0;
      s_ready    <= 1'b0;
      addr_ext   <= '0;
      wen_ext    <= 1'b0;
      wdata_ext  <= '0;
      cpu_enable <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state      <= RECV;
            s_ready    <= 1'b1;
            error      <= 1'b0;
            byte_idx   <= '0;
            word_idx   <= '0;
            word_count <= '0;
          end
        end
        RECV: begin
          if (accept) begin
            if (byte_idx == 2'd0 && word_idx == IDX_MAX) begin
              // Memory image full: the new word's first byte is dropped.
              state   <= ERR;
              s_ready <= 1'b0;
              error   <= 1'b1;
            end else if (byte_idx == 2'd3) begin
              state     <= WRITE;
              s_ready   <= 1'b0;
              wen_ext   <= 1'b1;
              addr_ext  <= wr_addr;
              wdata_ext <= {s_data, shadow};
              last_q    <= s_last;
            end else if (s_last) begin
              // Program ends mid-word: never write the partial word.
              state   <= ERR;
              s_ready <= 1'b0;
              error   <= 1'b1;
            end else begin
              shadow[{byte_idx, 3'b000} +: 8] <= s_data;
              byte_idx                        <= byte_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          wen_ext  <= 1'b0;
          byte_idx <= '0;
          word_idx <= word_idx + 1'b1;
          if (word_count != CNT_SAT)
            word_count <= word_count + 1'b1;
          if (last_q) begin
            state      <= RUN;
            cpu_enable <= 1'b1;
            done       <= 1'b1;
          end else begin
            state   <= RECV;
            s_ready <= 1'b1;
          end
        end
        RUN: ;
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          wen_ext <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: two instances share one stimulus stream and are
// checked every cycle against a byte-queue model of the load session.
module tb_imem_prog_loader;
  localparam int          MAXW = 2;
  localparam logic [63:0] B1   = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic rst, start, s_valid, s_last;
  logic [7:0] s_data;

  logic        rdy0, wen0, en0, done0, err0;
  logic [63:0] addr0;
  logic [31:0] data0;
  logic [15:0] wc0;
  logic        rdy1, wen1, en1, done1, err1;
  logic [63:0] addr1;
  logic [31:0] data1;
  logic [0:0]  wc1;

  imem_prog_loader #(.BASE_ADDR(64'd0), .MAX_WORDS(MAXW), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(rdy0), .addr_ext(addr0), .wen_ext(wen0),
    .wdata_ext(data0), .cpu_enable(en0), .done(done0), .error(err0),
    .word_count(wc0));

  imem_prog_loader #(.BASE_ADDR(B1), .MAX_WORDS(MAXW), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(rdy1), .addr_ext(addr1), .wen_ext(wen1),
    .wdata_ext(data1), .cpu_enable(en1), .done(done1), .error(err1),
    .word_count(wc1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Session model: bytes queue up until four form a word.
  localparam int M_IDLE = 0, M_RECV = 1, M_WRITE = 2, M_RUN = 3, M_ERR = 4;
  int          m_mode  = M_IDLE;
  int          m_words = 0;
  bit          m_last  = 1'b0;
  logic [7:0]  m_q[$];
  logic [31:0] m_data  = '0;
  logic [63:0] m_addr0 = '0;
  logic [63:0] m_addr1 = '0;

  task automatic model_step();
    if (rst) begin
      m_mode = M_IDLE; m_q.delete(); m_words = 0;
      m_data = '0; m_addr0 = '0; m_addr1 = '0;
    end else begin
      case (m_mode)
        M_IDLE, M_ERR: if (start) begin
          m_mode = M_RECV; m_q.delete(); m_words = 0;
        end
        M_RECV: if (s_valid) begin
          if (m_q.size() == 0 && m_words == MAXW) m_mode = M_ERR;
          else begin
            m_q.push_back(s_data);
            if (m_q.size() == 4) begin
              m_data = '0;
              for (int k = 0; k < 4; k++) m_data = m_data + (32'(m_q[k]) << (8 * k));
              m_addr0 = 64'(4 * m_words);
              m_addr1 = B1 + 64'(4 * m_words);
              m_last  = s_last;
              m_q.delete();
              m_mode = M_WRITE;
            end else if (s_last) m_mode = M_ERR;
          end
        end
        M_WRITE: begin
          m_words++;
          m_mode = m_last ? M_RUN : M_RECV;
        end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("d0_ready", rdy0,  m_mode == M_RECV);
      chk("d0_wen",   wen0,  m_mode == M_WRITE);
      chk("d0_en",    en0,   m_mode == M_RUN);
      chk("d0_done",  done0, m_mode == M_RUN);
      chk("d0_err",   err0,  m_mode == M_ERR);
      chk("d0_addr",  addr0, m_addr0);
      chk("d0_data",  data0, m_data);
      chk("d0_wc",    wc0,   64'(m_words));
      chk("d1_ready", rdy1,  m_mode == M_RECV);
      chk("d1_wen",   wen1,  m_mode == M_WRITE);
      chk("d1_en",    en1,   m_mode == M_RUN);
      chk("d1_err",   err1,  m_mode == M_ERR);
      chk("d1_addr",  addr1, m_addr1);
      chk("d1_data",  data1, m_data);
      chk("d1_wc",    wc1,   m_words > 0);
    end
  end

  // Log of dut0 writes for directed literal checks.
  logic [63:0] wq_a[$];
  logic [31:0] wq_d[$];
  initial forever begin
    @(negedge clk);
    if (wen0) begin
      wq_a.push_back(addr0);
      wq_d.push_back(data0);
    end
  end

  logic [7:0] sb [16];

  task automatic clr_log();
    wq_a.delete(); wq_d.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  // pv < 0: valid on alternating cycles; otherwise percent probability.
  task automatic load(input int n, input int last_at, input int pv,
                      input int stop_after, input bit rnd_start);
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    while (i < n && i < stop_after && cyc < 400) begin
      s_valid = (pv < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < pv);
      s_data  = sb[i];
      s_last  = (i == last_at);
      start   = rnd_start && ($urandom_range(9) == 0);
      acc     = s_valid && rdy0;
      @(negedge clk);
      cyc++;
      if (acc) i++;
      if (err0 || done0) break;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    if (cyc >= 400) chk("load_timeout", 64'(cyc), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_wen",  wen0,  0);
    chk("rst_addr", addr0, 0);
    chk("rst_wc",   wc0,   0);
    chk("rst_rdy",  rdy0,  0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal two-word program
    sb[0] = 8'h13; sb[1] = 8'h00; sb[2] = 8'h00; sb[3] = 8'h00;
    sb[4] = 8'h93; sb[5] = 8'h00; sb[6] = 8'h10; sb[7] = 8'h00;
    clr_log();
    pulse_start();
    load(8, 7, 100, 99, 1'b0);
    repeat (2) @(negedge clk);
    chk("nom_nwr",   64'(wq_a.size()), 2);
    chk("nom_a0",    wq_a[0], 64'd0);
    chk("nom_d0",    wq_d[0], 32'h0000_0013);
    chk("nom_a1",    wq_a[1], 64'd4);
    chk("nom_d1",    wq_d[1], 32'h0010_0093);
    chk("nom_model", m_data,  32'h0010_0093);
    chk("nom_wc",    wc0, 2);
    chk("nom_en",    en0, 1);

    // start during RUN is ignored
    pulse_start();
    repeat (3) @(negedge clk);
    chk("run_en", en0, 1);
    chk("run_wc", wc0, 2);

    // rst wins over start
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("pri_en",   en0,   0);
    chk("pri_rdy",  rdy0,  0);
    chk("pri_data", data0, 0);

    // Alternating-valid stream
    clr_log();
    pulse_start();
    load(8, 7, -1, 99, 1'b0);
    repeat (2) @(negedge clk);
    chk("bp_nwr", 64'(wq_a.size()), 2);
    chk("bp_d0",  wq_d[0], 32'h0000_0013);
    chk("bp_d1",  wq_d[1], 32'h0010_0093);
    chk("bp_done", done0, 1);

    // Truncated word, then recovery
    do_reset();
    clr_log();
    pulse_start();
    load(3, 2, 100, 99, 1'b0);
    @(negedge clk);
    chk("tr_err", err0, 1);
    chk("tr_nwr", 64'(wq_a.size()), 0);
    chk("tr_en",  en0, 0);
    pulse_start();
    load(4, 3, 100, 99, 1'b0);
    repeat (2) @(negedge clk);
    chk("tr_done", done0, 1);
    chk("tr_wc",   wc0, 1);
    chk("tr_nwr2", 64'(wq_a.size()), 1);

    // Overflow beyond two words
    for (int k = 0; k < 12; k++) sb[k] = 8'(k + 1);
    do_reset();
    clr_log();
    pulse_start();
    load(12, 11, 100, 99, 1'b0);
    repeat (2) @(negedge clk);
    chk("ov_nwr", 64'(wq_a.size()), 2);
    chk("ov_a1",  wq_a[1], 64'd4);
    chk("ov_d0",  wq_d[0], 32'h0403_0201);
    chk("ov_d1",  wq_d[1], 32'h0807_0605);
    chk("ov_err", err0, 1);
    chk("ov_d1addr", addr1, 64'd0);

    // Reset in the middle of the second word
    do_reset();
    pulse_start();
    load(8, -1, 100, 6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_data", data0, 0);
    chk("mr_wc",   wc0, 0);
    chk("mr_rdy",  rdy0, 0);
    clr_log();
    pulse_start();
    load(4, 3, 100, 99, 1'b0);
    repeat (2) @(negedge clk);
    chk("mr_a0", wq_a[0], 64'd0);
    chk("mr_wc2", wc0, 1);

    // Randomized sessions
    for (int it = 0; it < 60; it++) begin
      int n, la, pv, stp;
      if ($urandom_range(3) == 0) do_reset();
      for (int k = 0; k < 16; k++) sb[k] = 8'($urandom);
      n   = $urandom_range(1, 12);
      la  = $urandom_range(0, n);
      pv  = $urandom_range(30, 100);
      stp = ($urandom_range(4) == 0) ? $urandom_range(1, n) : 99;
      pulse_start();
      load(n, la, pv, stp, 1'b1);
      if (stp < n) do_reset();
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Boot-time loader upstream of the RISC-V CPU top.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through the CPU's external write port (addr_ext / wen_ext / wdata_ext).
- After the last word is written, raises the CPU enable so execution starts.

Parameters:
BASE_ADDR, 0, byte address of the first instruction word written
MAX_WORDS, 128, maximum number of words accepted before overflow error
CNT_W, 16, width of word_count output

Ports:
clk  input  1  main clock
rst  input  1  reset; synchronous, active-high
start  input  1  one-cycle pulse; begins a load session from IDLE or ERR
s_valid  input  1  byte stream valid
s_data  input  8  byte stream data
s_last  input  1  marks final byte of program; qualified by s_valid
s_ready  output  1  loader accepts byte this cycle
addr_ext  output  64  instruction memory external byte address
wen_ext  output  1  instruction memory external write enable
wdata_ext  output  32  instruction memory external write word
cpu_enable  output  1  drives CPU enable; high only in RUN
done  output  1  load completed successfully; high only in RUN
error  output  1  load aborted; high only in ERR
word_count  output  CNT_W  number of words written this session

Behaviour:
- Handshake: a byte is accepted only when s_valid && s_ready on a rising clk edge.
- Reset: rst sampled at clk edge.
  - FSM goes to IDLE.
  - All outputs 0 (addr_ext, wdata_ext, word_count included); byte index 0; word index 0.
  - Reset mid-session aborts immediately; words already written stay in memory.
- FSM states: IDLE, RECV, WRITE, RUN, ERR.
- IDLE:
  - s_ready=0, cpu_enable=0.
  - start=1 → RECV next cycle; clears byte index, word index, word_count.
- RECV:
  - s_ready=1.
  - Byte k (k=0..3) of the current word lands in shadow bits [8k+7:8k].
  - On accepting byte 0 with word index == MAX_WORDS → ERR; byte discarded, no write.
  - On accepting byte 3 → WRITE; remember s_last.
  - On accepting byte 0..2 with s_last=1 → ERR (truncated word); no write of the partial word.
  - start is ignored.
- WRITE (exactly 1 cycle):
  - s_ready=0, wen_ext=1.
  - addr_ext = BASE_ADDR + 4*word index, computed in 64-bit arithmetic, modulo 2^64.
  - wdata_ext = assembled word.
  - Next cycle: word index +1, word_count +1, byte index 0.
  - If remembered last=1 → RUN, else → RECV.
- Write outputs after WRITE:
  - addr_ext and wdata_ext hold their last values until the next WRITE or rst.
  - wen_ext=0 in every state except WRITE.
- Throughput: 4 accepted bytes + 1 write cycle per word, i.e. minimum 5 cycles/word.
- RUN:
  - cpu_enable=1 and done=1 continuously; s_ready=0.
  - start is ignored; only rst leaves RUN.
  - cpu_enable rises the cycle after the final wen_ext pulse.
- ERR:
  - error=1, s_ready=0, cpu_enable=0.
  - start=1 → RECV with counters cleared (same as from IDLE).
- Simultaneous events:
  - rst has priority over everything, including start.
  - s_last with byte 3 together with word index reaching MAX_WORDS after the write → RUN (full program is legal).
- word_count saturates at 2^CNT_W-1 if MAX_WORDS exceeds it.

Test Plan:
- Nominal load: start, then bytes 13 00 00 00 93 00 10 00 with s_last on byte 8, BASE_ADDR=0 → wen pulses with addr 0 / data 0x00000013 and addr 4 / data 0x00100093; word_count=2; cpu_enable=done=1 from the cycle after the 2nd wen and held.
- Backpressure and gaps: same stream with s_valid low on alternating cycles → identical writes; s_ready=0 during each WRITE cycle; no byte lost or duplicated.
- Truncation: s_last on byte 3 of the first word (index 2) → error=1 next cycle, wen_ext never asserted, cpu_enable=0; start afterwards reloads a correct 4-byte stream to RUN with word_count=1.
- Overflow: MAX_WORDS=2, 12-byte stream, s_last on byte 12 → two writes (addr 0, 4), error=1 upon acceptance of byte 9, no third write.
- Mid-session reset: rst asserted after 6 bytes → next cycle all outputs 0 and state IDLE; a following start + 4 bytes with s_last → write at addr 0 and word_count=1.
- Priority: start pulsed during RUN → no change; rst and start in the same cycle → IDLE with outputs 0.
